// File: rtl/wokwi_tile_395055035944909825_if.sv
// Tile I/O bundle: the mode/enable/operand byte going in and the registered result byte coming out.
interface wokwi_tile_395055035944909825_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/wokwi_tile_395055035944909825.sv
// Four-mode 8-bit utility tile: load, accumulating counter, 8-bit LFSR and PWM generator.
// The output byte is registered and shows the state after the same edge's update.
module wokwi_tile_395055035944909825 (
    input  logic                                  clk,
    input  logic                                  rst,
    wokwi_tile_395055035944909825_if.slave        bus
);

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting register.
    function automatic logic lfsr_fb(input logic [7:0] l);
        return l[7] ^ l[5] ^ l[4] ^ l[3];
    endfunction

    mode_e       mode_s;
    logic        en_s;
    logic [4:0]  op_s;

    logic [7:0]  acc_r;
    logic [7:0]  lfsr_r;
    logic [4:0]  pcnt_r;
    logic [7:0]  uo_r;

    logic [7:0]  acc_next_s;
    logic [7:0]  lfsr_next_s;
    logic [4:0]  pcnt_next_s;
    logic        pwm_next_s;
    logic [7:0]  uo_next_s;

    // Split the input byte into mode, enable and operand fields.
    always_comb begin
        mode_s = mode_e'(bus.ui_in[7:6]);
        en_s   = bus.ui_in[5];
        op_s   = bus.ui_in[4:0];
    end

    // Next-state for the selected engine; every other engine holds its value.
    always_comb begin
        acc_next_s  = acc_r;
        lfsr_next_s = lfsr_r;
        pcnt_next_s = pcnt_r;
        case (mode_s)
            MODE_LOAD: begin
                if (en_s) begin
                    acc_next_s = {3'b000, op_s};
                end else begin
                    acc_next_s = acc_r;
                end
            end
            MODE_COUNT: begin
                if (en_s) begin
                    acc_next_s = acc_r + {3'b000, op_s};
                end else begin
                    acc_next_s = acc_r;
                end
            end
            MODE_LFSR: begin
                if (en_s) begin
                    lfsr_next_s = {lfsr_r[6:0], lfsr_fb(lfsr_r)};
                end else begin
                    lfsr_next_s = lfsr_r;
                end
            end
            MODE_PWM: begin
                if (!en_s) begin
                    pcnt_next_s = pcnt_r;
                end else if (pcnt_r == 5'd30) begin
                    pcnt_next_s = 5'd0;
                end else begin
                    pcnt_next_s = pcnt_r + 5'd1;
                end
            end
            default: begin
                acc_next_s  = acc_r;
                lfsr_next_s = lfsr_r;
                pcnt_next_s = pcnt_r;
            end
        endcase
        // An all-zero LFSR would never leave zero, so it is kicked back to the seed unconditionally.
        if (lfsr_r == 8'h00) begin
            lfsr_next_s = 8'h01;
        end else begin
            lfsr_next_s = lfsr_next_s;
        end
    end

    // Output byte built from post-update state so there is no extra cycle of latency.
    always_comb begin
        pwm_next_s = (pcnt_next_s < op_s);
        uo_next_s  = 8'h00;
        case (mode_s)
            MODE_LOAD:  uo_next_s = acc_next_s;
            MODE_COUNT: uo_next_s = acc_next_s;
            MODE_LFSR:  uo_next_s = lfsr_next_s;
            MODE_PWM:   uo_next_s = {2'b10, pcnt_next_s, pwm_next_s};
            default:    uo_next_s = 8'h00;
        endcase
    end

    // State and output registers; reset wins over any engine activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= 8'h00;
            lfsr_r <= 8'h01;
            pcnt_r <= 5'd0;
            uo_r   <= 8'h00;
        end else begin
            acc_r  <= acc_next_s;
            lfsr_r <= lfsr_next_s;
            pcnt_r <= pcnt_next_s;
            uo_r   <= uo_next_s;
        end
    end

    assign bus.uo_out = uo_r;

endmodule

// File: tb/tb_wokwi_tile_395055035944909825.sv
// Directed-vector bench for the four-mode utility tile; expected values are hand-derived.
module tb_wokwi_tile_395055035944909825;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    wokwi_tile_395055035944909825_if bus ();

    wokwi_tile_395055035944909825 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one vector, take one rising edge, then settle before sampling.
    task automatic step(input logic r, input logic [1:0] mode, input logic en, input logic [4:0] op);
        rst       = r;
        bus.ui_in = {mode, en, op};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 2'b11, 1'b1, 5'h1F);
        step(1'b1, 2'b01, 1'b1, 5'h0A);
    endtask

    initial begin
        int ones;
        int bad_hdr;
        int early;
        logic [7:0] exp_acc;

        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.ui_in = 8'h00;

        // T1 reset
        do_reset();
        check("reset_uo", bus.uo_out, 8'h00);
        step(1'b0, 2'b10, 1'b0, 5'h00);
        check("reset_lfsr_seed", bus.uo_out, 8'h01);

        // T2 load then count with wrap
        do_reset();
        step(1'b0, 2'b00, 1'b1, 5'h15);
        check("load_15", bus.uo_out, 8'h15);
        exp_acc = 8'h15;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b01, 1'b1, 5'h1F);
            exp_acc = exp_acc + 8'h1F;
            check("count_step", bus.uo_out, exp_acc);
        end
        check("count_wrap_0d", bus.uo_out, 8'h0D);

        // T3 LFSR sequence and period
        do_reset();
        step(1'b0, 2'b10, 1'b1, 5'h00);
        check("lfsr_1", bus.uo_out, 8'h02);
        step(1'b0, 2'b10, 1'b1, 5'h00);
        check("lfsr_2", bus.uo_out, 8'h04);
        step(1'b0, 2'b10, 1'b1, 5'h00);
        check("lfsr_3", bus.uo_out, 8'h08);
        step(1'b0, 2'b10, 1'b1, 5'h00);
        check("lfsr_4", bus.uo_out, 8'h11);
        step(1'b0, 2'b10, 1'b1, 5'h00);
        check("lfsr_5", bus.uo_out, 8'h23);
        early = 0;
        for (int i = 6; i <= 255; i++) begin
            step(1'b0, 2'b10, 1'b1, 5'h00);
            if (i < 255 && (bus.uo_out == 8'h01 || bus.uo_out == 8'h00)) early++;
        end
        check("lfsr_period_255", bus.uo_out, 8'h01);
        check("lfsr_no_early_repeat", early, 0);

        // T4 PWM duty and wrap
        do_reset();
        ones = 0;
        bad_hdr = 0;
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 2'b11, 1'b1, 5'd10);
            ones += int'(bus.uo_out[0]);
            if (bus.uo_out[7:6] != 2'b10) bad_hdr++;
        end
        check("pwm_duty_10", ones, 10);
        check("pwm_header", bad_hdr, 0);
        check("pwm_pcnt_wrap", bus.uo_out[5:1], 5'd0);
        step(1'b0, 2'b11, 1'b1, 5'd10);
        check("pwm_after_wrap", bus.uo_out, {2'b10, 5'd1, 1'b1});
        ones = 0;
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 2'b11, 1'b1, 5'd0);
            ones += int'(bus.uo_out[0]);
        end
        check("pwm_op0_low", ones, 0);
        ones = 0;
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 2'b11, 1'b1, 5'd31);
            ones += int'(bus.uo_out[0]);
        end
        check("pwm_op31_high", ones, 31);

        // T5 hold in every mode, then mode switch keeps acc
        do_reset();
        step(1'b0, 2'b00, 1'b1, 5'h05);
        check("hold_load_seed", bus.uo_out, 8'h05);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0, 5'h1F);
        check("hold_load", bus.uo_out, 8'h05);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b0, 5'h1F);
        check("hold_count", bus.uo_out, 8'h05);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 1'b0, 5'h1F);
        check("hold_lfsr", bus.uo_out, 8'h01);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b11, 1'b0, 5'h1F);
        check("hold_pwm", bus.uo_out, 8'h81);
        step(1'b0, 2'b00, 1'b1, 5'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b1, 5'h10);
        check("count_to_40", bus.uo_out, 8'h40);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b1, 5'h00);
        check("switch_lfsr_resume", bus.uo_out, 8'h08);
        step(1'b0, 2'b01, 1'b0, 5'h10);
        check("acc_retained_40", bus.uo_out, 8'h40);

        // T6 reset mid-count
        do_reset();
        step(1'b0, 2'b00, 1'b1, 5'h1A);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b01, 1'b1, 5'h10);
        check("count_to_7a", bus.uo_out, 8'h7A);
        step(1'b1, 2'b01, 1'b1, 5'h10);
        check("midrun_reset_uo", bus.uo_out, 8'h00);
        step(1'b0, 2'b01, 1'b0, 5'h10);
        check("midrun_reset_acc", bus.uo_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
